// File: rtl/risc_pkg.sv
// Shared definitions for the RISC decode stage: sequencer state encoding,
// architectural sizes and the LM/SM opcodes that the decoder also uses.
package risc_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREG   = 8;
  localparam int unsigned RA_W   = 3;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

endpackage

// File: rtl/lm_sm_sequencer_pri_enc8.sv
// Lowest-set-bit priority encoder for an 8-bit register mask.
module pri_enc8 (
  input  logic [7:0] mask,
  output logic [2:0] idx,
  output logic       any
);

  logic found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (mask[i] && !found) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
    any = |mask;
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: walks the register mask lowest bit first, presenting one
// register/memory operation per cycle and stalling fetch while active.
module lm_sm_sequencer
  import risc_pkg::*;
#(
  parameter int unsigned DATA_W = risc_pkg::DATA_W,
  parameter int unsigned NREG   = risc_pkg::NREG,
  parameter int unsigned RA_W   = risc_pkg::RA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_lm,
  input  logic [NREG-1:0]   reg_mask,
  input  logic [DATA_W-1:0] base_addr,
  input  logic              stall_in,
  output logic              busy,
  output logic              stall_fetch,
  output logic              op_valid,
  output logic [RA_W-1:0]   reg_addr,
  output logic [DATA_W-1:0] mem_addr,
  output logic              reg_write,
  output logic              mem_write,
  output logic              done
);

  stateT             state, stateNext;
  logic [NREG-1:0]   maskQ;
  logic [NREG-1:0]   maskRest;
  logic [DATA_W-1:0] addrQ;
  logic              isLmQ;
  logic [2:0]        encIdx;
  logic              encAny;

  pri_enc8 uPriEnc (
    .mask (maskQ),
    .idx  (encIdx),
    .any  (encAny)
  );

  // x & (x-1) drops the lowest set bit, matching the encoder's choice.
  assign maskRest = maskQ & (maskQ - NREG'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      maskQ <= '0;
      addrQ <= '0;
      isLmQ <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == IDLE && start && reg_mask != '0) begin
        maskQ <= reg_mask;
        addrQ <= base_addr;
        isLmQ <= is_lm;
      end else if (state == RUN && !stall_in) begin
        maskQ <= maskRest;
        addrQ <= addrQ + DATA_W'(1);
      end
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (start) stateNext = (reg_mask != '0) ? RUN : DONE;
      RUN:  if (!stall_in && maskRest == '0) stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    stall_fetch = start || busy;
    op_valid    = (state == RUN) && encAny;
    reg_addr    = op_valid ? RA_W'(encIdx) : '0;
    mem_addr    = op_valid ? addrQ : '0;
    reg_write   = op_valid && isLmQ;
    mem_write   = op_valid && !isLmQ;
    done        = (state == DONE);
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed self-checking bench for lm_sm_sequencer with hand-computed vectors.
module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_lm = 1'b0;
  logic [7:0]  reg_mask = '0;
  logic [15:0] base_addr = '0;
  logic        stall_in = 1'b0;
  logic        busy, stall_fetch, op_valid, reg_write, mem_write, done;
  logic [2:0]  reg_addr;
  logic [15:0] mem_addr;

  int unsigned checks = 0;
  int unsigned errors = 0;

  lm_sm_sequencer #(.DATA_W(16), .NREG(8), .RA_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_lm       (is_lm),
    .reg_mask    (reg_mask),
    .base_addr   (base_addr),
    .stall_in    (stall_in),
    .busy        (busy),
    .stall_fetch (stall_fetch),
    .op_valid    (op_valid),
    .reg_addr    (reg_addr),
    .mem_addr    (mem_addr),
    .reg_write   (reg_write),
    .mem_write   (mem_write),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to the next cycle; inputs are driven shortly after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expectOp(input string tag, input logic [2:0] ra, input logic [15:0] ma,
                          input logic lm);
    settle();
    checkEq({tag, " op_valid"}, op_valid, 1);
    checkEq({tag, " reg_addr"}, reg_addr, ra);
    checkEq({tag, " mem_addr"}, mem_addr, ma);
    checkEq({tag, " reg_write"}, reg_write, lm);
    checkEq({tag, " mem_write"}, mem_write, !lm);
    checkEq({tag, " done"}, done, 0);
    checkEq({tag, " stall_fetch"}, stall_fetch, 1);
  endtask

  task automatic expectDone(input string tag);
    settle();
    checkEq({tag, " done"}, done, 1);
    checkEq({tag, " op_valid"}, op_valid, 0);
    checkEq({tag, " busy"}, busy, 1);
  endtask

  task automatic expectIdle(input string tag, input logic sf);
    settle();
    checkEq({tag, " busy"}, busy, 0);
    checkEq({tag, " done"}, done, 0);
    checkEq({tag, " op_valid"}, op_valid, 0);
    checkEq({tag, " stall_fetch"}, stall_fetch, sf);
  endtask

  task automatic launch(input string tag, input logic lm, input logic [7:0] m,
                        input logic [15:0] b);
    start = 1'b1;
    is_lm = lm;
    reg_mask = m;
    base_addr = b;
    settle();
    checkEq({tag, " c0 stall_fetch"}, stall_fetch, 1);
    checkEq({tag, " c0 op_valid"}, op_valid, 0);
    step();
    start = 1'b0;
    reg_mask = 8'h55;
    base_addr = 16'hDEAD;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    // Reset state
    #3;
    checkEq("rst busy", busy, 0);
    checkEq("rst op_valid", op_valid, 0);
    checkEq("rst reg_addr", reg_addr, 0);
    checkEq("rst mem_addr", mem_addr, 0);
    checkEq("rst done", done, 0);
    checkEq("rst stall_fetch", stall_fetch, 0);
    step();
    reset = 1'b1;
    step();

    // LM mask A5, base 0x0100; stall during DONE must not matter
    launch("lmA5", 1'b1, 8'b1010_0101, 16'h0100);
    expectOp("lmA5 c1", 3'd0, 16'h0100, 1'b1); step();
    expectOp("lmA5 c2", 3'd2, 16'h0101, 1'b1); step();
    expectOp("lmA5 c3", 3'd5, 16'h0102, 1'b1); step();
    expectOp("lmA5 c4", 3'd7, 16'h0103, 1'b1); step();
    stall_in = 1'b1;
    expectDone("lmA5 c5"); step();
    expectIdle("lmA5 c6", 1'b0);
    stall_in = 1'b0;
    step();

    // SM single R7 at 0xFFFF; start held across DONE launches the wrap test
    launch("sm80", 1'b0, 8'h80, 16'hFFFF);
    expectOp("sm80 c1", 3'd7, 16'hFFFF, 1'b0); step();
    start = 1'b1; is_lm = 1'b0; reg_mask = 8'h03; base_addr = 16'hFFFF;
    expectDone("sm80 c2"); step();
    expectIdle("wrap c3", 1'b1); step();
    start = 1'b0;
    expectOp("wrap c4", 3'd0, 16'hFFFF, 1'b0); step();
    expectOp("wrap c5", 3'd1, 16'h0000, 1'b0); step();
    expectDone("wrap c6"); step();
    expectIdle("wrap c7", 1'b0); step();

    // Stall in cycles 2-3 of LM mask 0F
    launch("stall", 1'b1, 8'h0F, 16'h0010);
    expectOp("stall c1", 3'd0, 16'h0010, 1'b1); step();
    stall_in = 1'b1;
    expectOp("stall c2", 3'd1, 16'h0011, 1'b1); step();
    expectOp("stall c3", 3'd1, 16'h0011, 1'b1); step();
    stall_in = 1'b0;
    expectOp("stall c4", 3'd1, 16'h0011, 1'b1); step();
    expectOp("stall c5", 3'd2, 16'h0012, 1'b1); step();
    expectOp("stall c6", 3'd3, 16'h0013, 1'b1); step();
    expectDone("stall c7"); step();
    expectIdle("stall c8", 1'b0); step();

    // Empty mask
    launch("empty", 1'b1, 8'h00, 16'h1234);
    expectDone("empty c1");
    checkEq("empty c1 stall_fetch", stall_fetch, 1);
    step();
    expectIdle("empty c2", 1'b0); step();

    // Reset mid-sequence, then a new start on the next edge
    launch("rst", 1'b1, 8'hFF, 16'h0020);
    expectOp("rst c1", 3'd0, 16'h0020, 1'b1); step();
    reset = 1'b0;
    settle();
    checkEq("rstmid op_valid", op_valid, 0);
    checkEq("rstmid reg_addr", reg_addr, 0);
    checkEq("rstmid mem_addr", mem_addr, 0);
    checkEq("rstmid reg_write", reg_write, 0);
    checkEq("rstmid busy", busy, 0);
    checkEq("rstmid done", done, 0);
    checkEq("rstmid stall_fetch", stall_fetch, 0);
    reset = 1'b1;
    launch("post", 1'b0, 8'h01, 16'h0040);
    expectOp("post c1", 3'd0, 16'h0040, 1'b0); step();
    expectDone("post c2"); step();
    expectIdle("post c3", 1'b0); step();

    // Start pulses while busy are ignored
    launch("ign", 1'b1, 8'h0E, 16'h0300);
    expectOp("ign c1", 3'd1, 16'h0300, 1'b1); step();
    start = 1'b1; is_lm = 1'b0; reg_mask = 8'hF0; base_addr = 16'h9000;
    expectOp("ign c2", 3'd2, 16'h0301, 1'b1); step();
    expectOp("ign c3", 3'd3, 16'h0302, 1'b1); step();
    start = 1'b0;
    expectDone("ign c4"); step();
    expectIdle("ign c5", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
